// File: rtl/turbo_pkg.sv
// Shared turbo-decoder definitions: QPP coefficients for the supported block
// sizes, the soft-symbol type, the de-interleaver read FSM states, and a
// reference QPP permutation function for benches.
package turbo_pkg;

  // Soft symbol carried between the constituent decoders
  localparam int SYM_BITS = 8;
  typedef logic [SYM_BITS-1:0] soft_sym_t;

  // QPP coefficients (F1, F2) per supported block length
  localparam int QPP_N40_F1 = 3;
  localparam int QPP_N40_F2 = 10;
  localparam int QPP_N48_F1 = 7;
  localparam int QPP_N48_F2 = 12;
  localparam int QPP_N56_F1 = 19;
  localparam int QPP_N56_F2 = 42;
  localparam int QPP_N64_F1 = 7;
  localparam int QPP_N64_F2 = 16;
  localparam int QPP_N72_F1 = 7;
  localparam int QPP_N72_F2 = 18;
  localparam int QPP_N80_F1 = 11;
  localparam int QPP_N80_F2 = 20;

  // Read-side states of the de-interleaver
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Direct-form permutation pi(i) = (F1*i + F2*i*i) mod N, wide enough that
  // no intermediate product overflows for any realistic block length.
  function automatic int qpp_pi(input int i, input int n, input int f1, input int f2);
    longint li;
    longint t;
    li = longint'(i);
    t  = (longint'(f1) * li + longint'(f2) * li * li) % longint'(n);
    return int'(t);
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Incremental QPP address generator. Produces pi(0), pi(1), ... one step per
// advance using the recurrence pi += g, g += 2*F2 (both mod N). Each sum is
// at most 2N-2, so one conditional subtract keeps it in range without any
// multiplier or divider. restart returns to pi(0) for the next block.
module qpp_addr_gen
  import turbo_pkg::*;
#(
  parameter int N  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 advance,
  input  logic                 restart,
  output logic [$clog2(N)-1:0] addr
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0]   N_W    = (AW+1)'(N);
  localparam logic [AW-1:0] G_INIT = AW'((F1 + F2) % N);
  localparam logic [AW-1:0] G_STEP = AW'((2 * F2) % N);

  logic [AW-1:0] pi_reg, pi_next;
  logic [AW-1:0] g_reg, g_next;
  logic [AW:0]   pi_sum, pi_wrap;
  logic [AW:0]   g_sum, g_wrap;

  // Next address and increment, each folded back below N by one subtract
  always_comb begin
    pi_sum  = {1'b0, pi_reg} + {1'b0, g_reg};
    pi_wrap = (pi_sum >= N_W) ? (pi_sum - N_W) : pi_sum;
    pi_next = pi_wrap[AW-1:0];
    g_sum   = {1'b0, g_reg} + {1'b0, G_STEP};
    g_wrap  = (g_sum >= N_W) ? (g_sum - N_W) : g_sum;
    g_next  = g_wrap[AW-1:0];
  end

  // Recurrence state; restart wins so the block boundary always lands on pi(0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pi_reg <= '0;
      g_reg  <= G_INIT;
    end else if (restart) begin
      pi_reg <= '0;
      g_reg  <= G_INIT;
    end else if (advance) begin
      pi_reg <= pi_next;
      g_reg  <= g_next;
    end
  end

  assign addr = pi_reg;

endmodule

// File: rtl/stream_deinterleaver.sv
// QPP stream de-interleaver: writes each interleaved block into one of two
// banks at address pi(i) and reads the other bank back in natural order.
// Optional out_last output (marks the symbol from address N-1) is enabled by
// defining STREAM_DEINTERLEAVER_LAST_EN.
module stream_deinterleaver
  import turbo_pkg::*;
#(
  parameter int BITS = 8,
  parameter int N    = 40,
  parameter int F1   = 3,
  parameter int F2   = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] data_out
`ifdef STREAM_DEINTERLEAVER_LAST_EN
  ,
  output logic            out_last
`endif
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  // Two block banks; contents are deliberately left unreset
  logic [BITS-1:0] mem [2][N];

  logic            wr_bank_reg, wr_bank_next;
  logic [AW-1:0]   wr_cnt_reg;
  logic [AW-1:0]   wr_addr;
  logic [1:0]      full_reg, full_next;
  logic            in_ready_reg;

  rd_state_t       rd_state_reg;
  logic            rd_bank_reg;
  logic [AW-1:0]   rd_idx_reg;
  logic            out_valid_reg;
  logic [BITS-1:0] data_out_reg;
`ifdef STREAM_DEINTERLEAVER_LAST_EN
  logic            out_last_reg;
`endif

  logic in_fire, wr_last, rd_issue, rd_last;

  assign in_fire  = in_valid && in_ready_reg;
  assign wr_last  = in_fire && (wr_cnt_reg == LAST_IDX);
  // Read whenever the output register is empty or is being emptied this cycle
  assign rd_issue = (rd_state_reg == RD_DRAIN) && (!out_valid_reg || out_ready);
  assign rd_last  = rd_issue && (rd_idx_reg == LAST_IDX);

  assign wr_bank_next = wr_bank_reg ^ wr_last;

  // Per-bank full flag: set by a completed write, cleared by the final read.
  // The two events never hit the same bank in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_full
      assign full_next[gi] = (full_reg[gi] | (wr_last && (wr_bank_reg == 1'(gi))))
                             & ~(rd_last && (rd_bank_reg == 1'(gi)));
    end
  endgenerate

  qpp_addr_gen #(
    .N  (N),
    .F1 (F1),
    .F2 (F2)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (in_fire),
    .restart (wr_last),
    .addr    (wr_addr)
  );

  // Bank write port: scatter each input symbol to its permuted address
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_bank_reg][wr_addr] <= data_in;
    end
  end

  // Write-side bookkeeping; in_ready looks ahead at the next-cycle full state
  // so a bank freed in the same cycle as the other one fills keeps input open
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_reg  <= 1'b0;
      wr_cnt_reg   <= '0;
      full_reg     <= 2'b00;
      in_ready_reg <= 1'b1;
    end else begin
      full_reg     <= full_next;
      wr_bank_reg  <= wr_bank_next;
      in_ready_reg <= !full_next[wr_bank_next];
      if (in_fire) begin
        wr_cnt_reg <= wr_last ? '0 : (wr_cnt_reg + 1'b1);
      end
    end
  end

  // Read FSM and registered output stage; uses next-cycle full flags so a
  // freshly completed block starts draining without an extra idle cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_reg  <= RD_IDLE;
      rd_bank_reg   <= 1'b0;
      rd_idx_reg    <= '0;
      out_valid_reg <= 1'b0;
      data_out_reg  <= '0;
`ifdef STREAM_DEINTERLEAVER_LAST_EN
      out_last_reg  <= 1'b0;
`endif
    end else begin
      if (rd_issue) begin
        data_out_reg  <= mem[rd_bank_reg][rd_idx_reg];
        out_valid_reg <= 1'b1;
`ifdef STREAM_DEINTERLEAVER_LAST_EN
        out_last_reg  <= (rd_idx_reg == LAST_IDX);
`endif
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (rd_state_reg)
        RD_IDLE: begin
          if (full_next[rd_bank_reg]) begin
            rd_state_reg <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (rd_last) begin
            rd_idx_reg   <= '0;
            rd_bank_reg  <= !rd_bank_reg;
            rd_state_reg <= full_next[!rd_bank_reg] ? RD_DRAIN : RD_IDLE;
          end else if (rd_issue) begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign data_out  = data_out_reg;
`ifdef STREAM_DEINTERLEAVER_LAST_EN
  assign out_last  = out_last_reg;
`endif

endmodule

// File: tb/tb_stream_deinterleaver.sv
// Directed bench for stream_deinterleaver (N=40, F1=3, F2=10): ramp,
// back-to-back blocks, output stall, random handshakes and mid-block reset.
module tb_stream_deinterleaver;
  import turbo_pkg::*;

  localparam int N    = 40;
  localparam int F1   = 3;
  localparam int F2   = 10;
  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] data_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] data_out;
`ifdef STREAM_DEINTERLEAVER_LAST_EN
  logic            out_last;
`endif

  always #5 clk = ~clk;

  stream_deinterleaver #(
    .BITS (BITS),
    .N    (N),
    .F1   (F1),
    .F2   (F2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef STREAM_DEINTERLEAVER_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int in_stall_cycles = 0;
  bit in_timeout = 1'b0;

  int              in_cyc_q[$];
  int              out_cyc_q[$];
  logic [BITS-1:0] out_q[$];
  logic [BITS-1:0] exp_q[$];
  logic            last_q[$];
  logic [BITS-1:0] in_seq[$];

  // Transfer monitor: records every accepted input and output
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && in_valid && in_ready) in_cyc_q.push_back(cyc);
    if (reset_n && out_valid && out_ready) begin
      out_q.push_back(data_out);
      out_cyc_q.push_back(cyc);
`ifdef STREAM_DEINTERLEAVER_LAST_EN
      last_q.push_back(out_last);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [BITS-1:0] sym(input int base, input int x);
    return BITS'(base + x);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    in_cyc_q.delete();
    out_cyc_q.delete();
    out_q.delete();
    exp_q.delete();
    last_q.delete();
  endtask

  // Present one symbol and hold it until accepted (bounded)
  task automatic send(input logic [BITS-1:0] d);
    int   waits;
    logic fired;
    waits    = 0;
    in_valid = 1'b1;
    data_in  = d;
    forever begin
      fired = in_ready;
      @(posedge clk);
      #1;
      if (fired) break;
      waits++;
      in_stall_cycles++;
      if (waits > 2000) begin
        in_timeout = 1'b1;
        break;
      end
    end
  endtask

  // Send one block whose natural-order content is base+0 .. base+N-1
  task automatic send_block(input int base);
    for (int i = 0; i < N; i++) send(sym(base, qpp_pi(i, N, F1, F2)));
    for (int x = 0; x < N; x++) exp_q.push_back(sym(base, x));
  endtask

  task automatic wait_outs(input int n, input string tag);
    int budget;
    budget = 3000;
    while (out_q.size() < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check({tag, "_count"}, out_q.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
      if (out_q[k] !== exp_q[k]) mism++;
    check(tag, mism, 0);
  endtask

  task automatic check_gaps(input string tag);
    int gaps;
    gaps = 0;
    for (int k = 1; k < out_cyc_q.size(); k++)
      if (out_cyc_q[k] - out_cyc_q[k-1] != 1) gaps++;
    check(tag, gaps, 0);
  endtask

  initial begin
    int lat;
    int lastn;
    int pos;
    int budget;
    logic fired;

    // Reset state
    reset_n = 1'b0;
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef STREAM_DEINTERLEAVER_LAST_EN
    check("rst_out_last", out_last, 0);
`endif
    reset_n = 1'b1;
    idle(2);
    clear_q();

    // Inverse ramp: feed pi(i), expect 0..39 in order
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(BITS'(qpp_pi(i, N, F1, F2)));
    in_valid = 1'b0;
    wait_outs(N, "ramp");
    for (int k = 0; k < N; k++)
      if (k < out_q.size()) check($sformatf("ramp_%0d", k), out_q[k], k);
    lat = (out_cyc_q.size() > 0 && in_cyc_q.size() == N) ? (out_cyc_q[0] - in_cyc_q[N-1]) : -1;
    check("ramp_latency", lat, 2);
    check_gaps("ramp_gaps");
`ifdef STREAM_DEINTERLEAVER_LAST_EN
    lastn = 0;
    foreach (last_q[k]) if (last_q[k] === 1'b1) lastn++;
    check("ramp_last_count", lastn, 1);
    if (last_q.size() == N) check("ramp_last_pos", last_q[N-1], 1);
`else
    lastn = 0;
`endif
    idle(3);
    clear_q();

    // Back-to-back blocks with input held valid
    in_stall_cycles = 0;
    for (int b = 0; b < 4; b++) send_block(b * 40 + 5);
    in_valid = 1'b0;
    check("b2b_in_stalls", in_stall_cycles, 0);
    wait_outs(4 * N, "b2b");
    compare_stream("b2b_order");
    check_gaps("b2b_gaps");
    idle(3);
    clear_q();

    // Output stall: two blocks fill both banks, then input must stop
    out_ready = 1'b0;
    send_block(64);
    check("stall_ready_after_first", in_ready, 1);
    send_block(128);
    in_valid = 1'b0;
    check("stall_in_ready_fall", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_data0", data_out, 64);
    idle(6);
    check("stall_data_hold", data_out, 64);
    check("stall_no_xfer", out_q.size(), 0);
    check("stall_in_ready_low", in_ready, 0);
`ifdef STREAM_DEINTERLEAVER_LAST_EN
    check("stall_last_low", out_last, 0);
`endif
    out_ready = 1'b1;
    send_block(192);
    in_valid = 1'b0;
    wait_outs(3 * N, "stall");
    compare_stream("stall_order");
    idle(3);
    clear_q();

    // Random handshakes over 20 blocks
    in_seq.delete();
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < N; i++) in_seq.push_back(sym(b * 37 + 3, qpp_pi(i, N, F1, F2)));
      for (int x = 0; x < N; x++) exp_q.push_back(sym(b * 37 + 3, x));
    end
    pos = 0;
    budget = 20000;
    while ((pos < 20 * N || out_q.size() < 20 * N) && budget > 0) begin
      in_valid  = (pos < 20 * N) && ($urandom_range(0, 1) == 1);
      if (pos < 20 * N) data_in = in_seq[pos];
      out_ready = ($urandom_range(0, 1) == 1);
      fired = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fired) pos++;
      budget--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_inputs", pos, 20 * N);
    check("rand_count", out_q.size(), 20 * N);
    compare_stream("rand_order");
    idle(3);
    clear_q();

    // Mid-block reset after 17 inputs of the second block
    out_ready = 1'b0;
    send_block(10);
    for (int i = 0; i < 17; i++) send(sym(100, qpp_pi(i, N, F1, F2)));
    check("prerst_out_valid", out_valid, 1);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_data_out", data_out, 0);
    idle(2);
    reset_n = 1'b1;
    clear_q();
    idle(1);
    out_ready = 1'b1;
    send_block(77);
    in_valid = 1'b0;
    wait_outs(N, "post_rst");
    compare_stream("post_rst_order");
    idle(10);
    check("post_rst_no_extra", out_q.size(), N);
    check("in_timeout", in_timeout, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/stream_deinterleaver.md
Name: stream_deinterleaver

Overview:
- Inverse of the forward stream interleaver used between the two constituent decoders of the max-product turbo decoder.
- Accepts blocks of N soft symbols in interleaved order and emits them in natural order.
- Permutation is QPP: pi(i) = (F1*i + F2*i*i) mod N. Forward interleaving is defined as y[i] = x[pi(i)]; this block restores x.
- Ping-pong buffered with valid/ready handshakes on both sides, so input and output can stall independently.

Parameters:
- BITS, 8, symbol width.
- N, 40, block length in symbols (>= 2).
- F1, 3, QPP linear coefficient (0 < F1 < N).
- F2, 10, QPP quadratic coefficient (0 <= F2 < N).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in holds a valid symbol.
- in_ready  output  1  block can accept a symbol; transfer occurs when in_valid && in_ready.
- data_in  input  BITS  interleaved-order symbol.
- out_valid  output  1  data_out holds a valid symbol.
- out_ready  input  1  sink accepts; transfer occurs when out_valid && out_ready.
- data_out  output  BITS  natural-order symbol.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, data_out=0, in_ready=1.
  - Both banks empty; write bank=0, read bank=0.
  - Write index i=0, pi=0, increment g=(F1+F2) mod N; read index=0.
  - Buffer contents are not reset.
  - Reset mid-block discards all partial and complete blocks.
- Write side:
  - Each input transfer stores data_in at address pi(i) of the write bank, then advances i.
  - Address update: pi <= (pi+g) mod N; g <= (g+2*F2) mod N.
  - Both values are kept < N using $clog2(N)+1-bit sums and a single conditional subtract of N. No multiplier or divider.
- Block completion:
  - On the transfer with i==N-1: mark the write bank full, toggle the write bank, and reset i=0, pi=0, g=(F1+F2) mod N.
  - in_ready = !full[write bank], registered, so it falls the cycle after the second bank fills.
- Read side (states IDLE, DRAIN):
  - IDLE -> DRAIN when full[read bank] is set.
  - In DRAIN, issue a read of address rd_idx when the output register is empty or being consumed that cycle (out_ready && out_valid). data_out and out_valid are registered from that read.
  - On issuing rd_idx==N-1: clear full[read bank] (effective the next cycle), toggle the read bank, set rd_idx=0, and return to IDLE. If the other bank is already full, go straight back to DRAIN with no gap.
- Latency: with an idle read side and out_ready=1:
  - first out_valid occurs 2 cycles after the last input transfer of the block;
  - then one symbol per cycle, N consecutive cycles.
- Backpressure: while out_valid && !out_ready, data_out holds stable and rd_idx does not advance.
- Simultaneous events:
  - A bank freed and the opposite bank filled in the same cycle are both honoured.
  - A write to one bank and a read from the other in the same cycle is always legal. The same bank is never read and written at once.
- Throughput: sustained one symbol per cycle in and out. in_ready never drops if out_ready stays 1.

Optional Feature:
- Macro STREAM_DEINTERLEAVER_LAST_EN.
- Defined: adds output port out_last (1 bit), registered alongside data_out. It is high exactly with the symbol read from address N-1 and reset to 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package turbo_pkg holds:
  - QPP coefficient constants for the supported block sizes;
  - a function qpp_pi(i, N, F1, F2) for benches;
  - the typedef for the symbol type.
- One sub-module, qpp_addr_gen:
  - inputs: clk, reset_n, advance, restart;
  - output: addr;
  - implements the incremental pi/g recurrence.
- The bank memories and the read FSM stay in stream_deinterleaver.

Test Plan:
- Inverse ramp:
  - Stimulus: N=40, F1=3, F2=10; feed data_in=pi(i) for i=0..39 (0,13,6,19,...), in_valid and out_ready held at 1.
  - Response: data_out = 0,1,...,39; first out_valid 2 cycles after the last input.
- Back-to-back blocks:
  - Stimulus: 4 consecutive blocks with in_valid held at 1.
  - Response: in_ready stays 1; 160 outputs with no gaps after the first latency; every block in natural order.
- Output stall:
  - Stimulus: out_ready=0 after the first output, input continues.
  - Response: data_out holds 0; in_ready falls 1 cycle after the second block completes; no data lost after out_ready returns.
- Random handshakes:
  - Stimulus: random in_valid/out_ready at 50% over 20 blocks.
  - Response: the scoreboard built from qpp_pi shows exact natural-order recovery.
- Mid-block reset:
  - Stimulus: assert reset_n low after 17 inputs of block 2.
  - Response: out_valid=0 immediately, in_ready=1; the next full block is recovered correctly.
- Optional feature (with STREAM_DEINTERLEAVER_LAST_EN):
  - Response: out_last high only with value 39 in the ramp test, held stable under a stall.
